// File: rtl/sdp_x_relu_core_dp.sv
// SDP X-path ReLU/clip datapath stage: one register slice, per-layer cfg snapshot, last-beat tagging.
// Optional perf counters enabled by defining SDP_RELU_CORE_PERF_CNT_EN.
module sdp_x_relu_core_dp #(
    parameter int NUM_ELEM = 16,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 16
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    input  logic                         chn_in_pvld,
    output logic                         chn_in_prdy,
    input  logic [NUM_ELEM*DATA_W-1:0]   chn_in_pd,
    input  logic                         cfg_relu_bypass,
    input  logic                         cfg_relu_clip,
    input  logic [DATA_W-1:0]            cfg_clip_max,
    input  logic [LEN_W-1:0]             cfg_len,
    output logic                         chn_out_pvld,
    input  logic                         chn_out_prdy,
    output logic [NUM_ELEM*DATA_W-1:0]   chn_out_pd,
    output logic                         chn_out_last,
    output logic                         layer_done,
`ifdef SDP_RELU_CORE_PERF_CNT_EN
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_clip_cnt,
`endif
    output logic                         core_wen,
    input  logic [1:0]                   fsm_output,
    output logic                         core_idle
);

    logic                       in_hs;
    logic                       out_hs;
    logic                       first_beat;
    logic                       in_last;
    logic [LEN_W-1:0]           in_cnt;
    logic [LEN_W-1:0]           out_cnt;
    logic                       bypass_sh;
    logic                       clip_sh;
    logic signed [DATA_W-1:0]   clip_max_sh;
    logic [LEN_W-1:0]           len_sh;
    logic                       eff_bypass;
    logic                       eff_clip;
    logic signed [DATA_W-1:0]   eff_max;
    logic [LEN_W-1:0]           eff_len;
    logic signed [DATA_W-1:0]   x_e [NUM_ELEM];
    logic [NUM_ELEM*DATA_W-1:0] y_pd;
    logic [NUM_ELEM-1:0]        sat;

    assign chn_in_prdy = ~chn_out_pvld | chn_out_prdy;
    assign in_hs       = chn_in_pvld & chn_in_prdy;
    assign out_hs      = chn_out_pvld & chn_out_prdy;
    assign core_wen    = in_hs;
    assign core_idle   = fsm_output[0] | ~chn_out_pvld;

    // The first beat of a layer sees the live cfg; later beats see the snapshot.
    assign first_beat = (in_cnt == '0);
    assign eff_bypass = first_beat ? cfg_relu_bypass : bypass_sh;
    assign eff_clip   = first_beat ? cfg_relu_clip : clip_sh;
    assign eff_max    = first_beat ? cfg_clip_max : clip_max_sh;
    assign eff_len    = first_beat ? cfg_len : len_sh;
    assign in_last    = (in_cnt == eff_len);

    always_comb begin
        y_pd = '0;
        sat  = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            x_e[i] = chn_in_pd[i*DATA_W +: DATA_W];
            if (eff_bypass) begin
                y_pd[i*DATA_W +: DATA_W] = x_e[i];
            end else if (x_e[i] < 0) begin
                y_pd[i*DATA_W +: DATA_W] = '0;
            end else if (eff_clip && eff_max < 0) begin
                y_pd[i*DATA_W +: DATA_W] = '0;
            end else if (eff_clip && x_e[i] > eff_max) begin
                y_pd[i*DATA_W +: DATA_W] = eff_max;
                sat[i] = 1'b1;
            end else begin
                y_pd[i*DATA_W +: DATA_W] = x_e[i];
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            chn_out_pvld <= 1'b0;
            chn_out_pd   <= '0;
            chn_out_last <= 1'b0;
            layer_done   <= 1'b0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            bypass_sh    <= 1'b0;
            clip_sh      <= 1'b0;
            clip_max_sh  <= '0;
            len_sh       <= '0;
        end else begin
            if (in_hs) begin
                chn_out_pd   <= y_pd;
                chn_out_last <= in_last;
                chn_out_pvld <= 1'b1;
            end else if (out_hs) begin
                chn_out_pvld <= 1'b0;
            end
            if (in_hs && first_beat) begin
                bypass_sh   <= cfg_relu_bypass;
                clip_sh     <= cfg_relu_clip;
                clip_max_sh <= cfg_clip_max;
                len_sh      <= cfg_len;
            end
            if (in_hs) begin
                in_cnt <= in_last ? '0 : in_cnt + 1'b1;
            end
            if (out_hs) begin
                out_cnt <= chn_out_last ? '0 : out_cnt + 1'b1;
            end
            layer_done <= out_hs & chn_out_last;
        end
    end

`ifdef SDP_RELU_CORE_PERF_CNT_EN
    logic [31:0] sat_num;
    logic [32:0] clip_sum;

    always_comb begin
        sat_num = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            sat_num = sat_num + 32'(sat[i]);
        end
    end

    assign clip_sum = {1'b0, perf_clip_cnt} + {1'b0, sat_num};

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_stall_cnt <= '0;
            perf_clip_cnt  <= '0;
        end else begin
            if (chn_out_pvld && !chn_out_prdy && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (in_hs) begin
                perf_clip_cnt <= clip_sum[32] ? '1 : clip_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdp_x_relu_core_dp.sv
// Directed scoreboard bench for sdp_x_relu_core_dp.
// Perf counter checks are compiled in when SDP_RELU_CORE_PERF_CNT_EN is defined.
module tb_sdp_x_relu_core_dp;

    localparam int NE = 16;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int PW = NE * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_pvld = 1'b0;
    logic          in_prdy;
    logic [PW-1:0] in_pd = '0;
    logic          cfg_bypass = 1'b0;
    logic          cfg_clip = 1'b0;
    logic [DW-1:0] cfg_max = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          out_pvld;
    logic          out_prdy = 1'b1;
    logic [PW-1:0] out_pd;
    logic          out_last;
    logic          layer_done;
    logic          core_wen;
    logic [1:0]    fsm = 2'b01;
    logic          core_idle;
`ifdef SDP_RELU_CORE_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_clip_cnt;
    logic [31:0]   base;
`endif

    always #5 clk = ~clk;

    sdp_x_relu_core_dp dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .chn_in_pvld     (in_pvld),
        .chn_in_prdy     (in_prdy),
        .chn_in_pd       (in_pd),
        .cfg_relu_bypass (cfg_bypass),
        .cfg_relu_clip   (cfg_clip),
        .cfg_clip_max    (cfg_max),
        .cfg_len         (cfg_len),
        .chn_out_pvld    (out_pvld),
        .chn_out_prdy    (out_prdy),
        .chn_out_pd      (out_pd),
        .chn_out_last    (out_last),
        .layer_done      (layer_done),
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_clip_cnt   (perf_clip_cnt),
`endif
        .core_wen        (core_wen),
        .fsm_output      (fsm),
        .core_idle       (core_idle)
    );

    typedef struct packed {
        logic [PW-1:0] pd;
        logic          last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic prev_ld = 1'b0;
    int   c;

    // Elements 0..3 carry the given values, the rest are zero.
    function automatic logic [PW-1:0] mk(input logic [DW-1:0] a, b, d, e);
        logic [PW-1:0] r;
        r = '0;
        r[0*DW +: DW] = a;
        r[1*DW +: DW] = b;
        r[2*DW +: DW] = d;
        r[3*DW +: DW] = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [PW-1:0] d, input logic [PW-1:0] y,
                        input logic lst, output int cyc);
        bit done;
        done = 1'b0;
        cyc = 0;
        in_pd = d;
        in_pvld = 1'b1;
        while (!done && cyc <= 50) begin
            @(negedge clk);
            if (in_prdy) begin
                chk("core_wen_hs", core_wen, 1'b1);
                q.push_back('{pd: y, last: lst});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) chk("send_timeout", done, 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("layer_done", layer_done, prev_ld);
            if (out_pvld && out_prdy) begin
                chk("sb_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("out_pd", out_pd, mon_e.pd);
                    chk("out_last", out_last, mon_e.last);
                end
                prev_ld = out_last;
            end else begin
                prev_ld = 1'b0;
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pvld", out_pvld, 1'b0);
        chk("rst_pd", out_pd, '0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_layer_done", layer_done, 1'b0);
        chk("rst_idle", core_idle, 1'b1);
        chk("rst_in_prdy", in_prdy, 1'b1);
        rstn = 1'b1;
        fsm = 2'b10;
        prev_ld = 1'b0;
        mon_en = 1'b1;

        // ReLU
        send(mk(32'hFFFF_FFFB, 32'h0, 32'h7, 32'h8000_0000),
             mk(32'h0, 32'h0, 32'h7, 32'h0), 1'b1, c);
        in_pvld = 1'b0;
        chk("relu_latency", out_pvld, 1'b1);
        @(negedge clk);
        chk("core_wen_once", core_wen, 1'b0);
        @(posedge clk);
        #1;

        // clip, positive bound
        cfg_clip = 1'b1;
        cfg_max = 32'd100;
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        base = perf_clip_cnt;
`endif
        send(mk(32'd150, 32'd100, 32'hFFFF_FFFF, 32'd42),
             mk(32'd100, 32'd100, 32'h0, 32'd42), 1'b1, c);
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        chk("perf_clip_1", perf_clip_cnt, base + 32'd1);
`endif
        // clip, negative bound
        cfg_max = 32'hFFFF_FFFD;
        send(mk(32'd150, 32'd100, 32'hFFFF_FFFF, 32'd42), '0, 1'b1, c);
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        chk("perf_clip_neg", perf_clip_cnt, base + 32'd1);
`endif
        in_pvld = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // backpressure
        cfg_clip = 1'b0;
        cfg_bypass = 1'b1;
        send(mk(32'd1, 32'd2, 32'd3, 32'd4), mk(32'd1, 32'd2, 32'd3, 32'd4), 1'b1, c);
        out_prdy = 1'b0;
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        base = perf_stall_cnt;
`endif
        in_pd = mk(32'd5, 32'd6, 32'd7, 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_prdy", in_prdy, 1'b0);
            chk("bp_core_wen", core_wen, 1'b0);
            chk("bp_pd_stable", out_pd, mk(32'd1, 32'd2, 32'd3, 32'd4));
            chk("bp_idle", core_idle, 1'b0);
            @(posedge clk);
            #1;
        end
`ifdef SDP_RELU_CORE_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, base + 32'd5);
`endif
        out_prdy = 1'b1;
        send(mk(32'd5, 32'd6, 32'd7, 32'd8), mk(32'd5, 32'd6, 32'd7, 32'd8), 1'b1, c);
        chk("bp_release_cyc", c, 1);
        in_pvld = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // layer of 3 beats, cfg_len changed mid-layer, then a second layer
        cfg_bypass = 1'b0;
        cfg_len = 16'd2;
        send(mk(32'd11, 32'd0, 32'd0, 32'd1), mk(32'd11, 32'd0, 32'd0, 32'd1), 1'b0, c);
        cfg_len = 16'd0;
        send(mk(32'd12, 32'd0, 32'd0, 32'd2), mk(32'd12, 32'd0, 32'd0, 32'd2), 1'b0, c);
        send(mk(32'd13, 32'd0, 32'd0, 32'd3), mk(32'd13, 32'd0, 32'd0, 32'd3), 1'b1, c);
        cfg_len = 16'd2;
        send(mk(32'd14, 32'd0, 32'd0, 32'd4), mk(32'd14, 32'd0, 32'd0, 32'd4), 1'b0, c);
        send(mk(32'd15, 32'd0, 32'd0, 32'd5), mk(32'd15, 32'd0, 32'd0, 32'd5), 1'b0, c);
        send(mk(32'd16, 32'd0, 32'd0, 32'd6), mk(32'd16, 32'd0, 32'd0, 32'd6), 1'b1, c);
        in_pvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // back-to-back layers A (ReLU, 2 beats) then B (bypass)
        cfg_len = 16'd1;
        send(mk(32'hFFFF_FFFF, 32'd9, 32'd0, 32'd0), mk(32'd0, 32'd9, 32'd0, 32'd0), 1'b0, c);
        send(mk(32'd21, 32'hFFFF_FF00, 32'd0, 32'd0), mk(32'd21, 32'd0, 32'd0, 32'd0), 1'b1, c);
        cfg_bypass = 1'b1;
        cfg_len = 16'd0;
        send(mk(32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFF),
             mk(32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFF), 1'b1, c);
        chk("b2b_no_bubble", c, 1);
        in_pvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // async reset mid-layer
        cfg_len = 16'd3;
        out_prdy = 1'b0;
        send(mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0),
             mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0), 1'b0, c);
        in_pvld = 1'b0;
        #2;
        mon_en = 1'b0;
        rstn = 1'b0;
        fsm = 2'b01;
        #1;
        chk("arst_pvld", out_pvld, 1'b0);
        chk("arst_last", out_last, 1'b0);
        chk("arst_layer_done", layer_done, 1'b0);
        chk("arst_idle", core_idle, 1'b1);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fsm = 2'b10;
        out_prdy = 1'b1;
        cfg_bypass = 1'b0;
        cfg_len = 16'd0;
        prev_ld = 1'b0;
        mon_en = 1'b1;
        send(mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd5, 32'd0),
             mk(32'd0, 32'd0, 32'd5, 32'd0), 1'b1, c);
        in_pvld = 1'b0;

        // drain
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
